// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the EXE-stage HI/LO multiply/divide sequencer:
// ALU function codes, FSM state encoding and the divide-by-zero LO value.
package muldiv_sequencer_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_iter_core.sv
// One radix-2 restoring divide step on {remainder, quotient}: shift in the
// next dividend bit, subtract the divisor if it fits, record the quotient bit.
module div_iter_core #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] partial;
  logic [W:0] diff;

  // rem < divisor always holds, so partial < 2*divisor and diff[W] is a clean borrow.
  always_comb begin
    partial  = {rem, quo[W-1]};
    diff     = partial - {1'b0, divisor};
    rem_next = diff[W] ? partial[W-1:0] : diff[W-1:0];
    quo_next = {quo[W-2:0], ~diff[W]};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer beside the EXE-stage ALU: holds the pipeline
// with stall_req while a 2-cycle multiply or iterative divide runs.
//
// state   | meaning
// IDLE    | waiting; a muldiv func with in_valid starts an operation
// MUL_RUN | product of the captured operands registered into HI/LO
// DIV_RUN | one restoring iteration per cycle on operand magnitudes
// DONE    | one-cycle HI/LO write pulse; pipeline advances
module muldiv_sequencer #(
  parameter int DIV_ITER = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  import muldiv_sequencer_pkg::*;

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  md_state_e state, state_next;

  logic              start;
  logic              load, mul_fire, div_step, div_last;
  logic [CNT_W-1:0]  cnt;
  logic              op_signed;
  logic [DATA_W-1:0] a_reg, b_reg, rem_reg, quo_reg, hi_reg, lo_reg;
  logic [DATA_W-1:0] divisor, rem_next, quo_next, src_a_mag;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;

  assign start = (state == MD_IDLE) & in_valid & ~flush & is_muldiv(func);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    load         = 1'b0;
    mul_fire     = 1'b0;
    div_step     = 1'b0;
    div_last     = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          load      = 1'b1;
          if (!is_div(func))     state_next = MD_MUL;
          else if (src_b == '0)  state_next = MD_DONE;
          else                   state_next = MD_DIV;
        end
      end
      MD_MUL: begin
        stall_req = ~flush;
        if (flush) state_next = MD_IDLE;
        else begin
          mul_fire   = 1'b1;
          state_next = MD_DONE;
        end
      end
      MD_DIV: begin
        stall_req = ~flush;
        if (flush) state_next = MD_IDLE;
        else begin
          div_step = 1'b1;
          if (cnt == CNT_LAST) begin
            div_last   = 1'b1;
            state_next = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        result_valid = ~flush;
        state_next   = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign src_a_mag = (is_signed_op(func) && src_a[DATA_W-1]) ? -src_a : src_a;
  assign divisor   = (op_signed && b_reg[DATA_W-1]) ? -b_reg : b_reg;

  div_iter_core #(.W(DATA_W)) u_div_iter_core (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // 33x33 signed product equals the low 64 bits of the sign-extended 64x64 product.
  assign mul_a   = {{DATA_W{op_signed & a_reg[DATA_W-1]}}, a_reg};
  assign mul_b   = {{DATA_W{op_signed & b_reg[DATA_W-1]}}, b_reg};
  assign product = mul_a * mul_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_signed <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      if (load) begin
        cnt       <= '0;
        op_signed <= is_signed_op(func);
        a_reg     <= src_a;
        b_reg     <= src_b;
        rem_reg   <= '0;
        quo_reg   <= src_a_mag;
        if (is_div(func) && src_b == '0) begin
          hi_reg <= src_a;
          lo_reg <= DATA_W'(DIV_BY_ZERO_LO);
        end
      end
      if (mul_fire) begin
        hi_reg <= product[2*DATA_W-1:DATA_W];
        lo_reg <= product[DATA_W-1:0];
      end
      if (div_step) begin
        cnt     <= cnt + CNT_W'(1);
        rem_reg <= rem_next;
        quo_reg <= quo_next;
      end
      if (div_last) begin
        lo_reg <= (op_signed && (a_reg[DATA_W-1] ^ b_reg[DATA_W-1])) ? -quo_next : quo_next;
        hi_reg <= (op_signed && a_reg[DATA_W-1]) ? -rem_next : rem_next;
      end
    end
  end

  assign busy = (state != MD_IDLE);
  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, signed/unsigned
// results, divide-by-zero, flush and mid-operation reset.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  func = 6'h00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy, result_valid;
  logic [31:0] hi_o, lo_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DIV_ITER(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .func         (func),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .stall_req    (stall_req),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller positions at the negedge of the accept cycle T0.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    int stalls;
    bit got;
    in_valid = 1'b1; func = f; src_a = a; src_b = b;
    #1;
    check({tag, " busy_t0"}, 64'(busy), 64'd0);
    stalls = stall_req ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      in_valid = 1'b0; func = F_ADD; src_a = ~a; src_b = a ^ b ^ 32'h5A5A_0001;
      #1;
      cyc++;
      if (result_valid) got = 1'b1;
      else if (stall_req) stalls++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, " stall_at_done"}, 64'(stall_req), 64'd0);
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    @(negedge clk);
    #1;
    check({tag, " rv_after"}, 64'(result_valid), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rv", 64'(result_valid), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    @(negedge clk); rst = 1'b1;

    @(negedge clk); run_op("divu_100_7",  F_DIVU,  32'd100,        32'd7,          33, 32'd2,          32'd14);
    @(negedge clk); run_op("div_m7_2",    F_DIV,   32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFF,  32'hFFFF_FFFD);
    @(negedge clk); run_op("div_7_m2",    F_DIV,   32'd7,          32'hFFFF_FFFE,  33, 32'd1,          32'hFFFF_FFFD);
    @(negedge clk); run_op("div_min_m1",  F_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,          32'h8000_0000);
    @(negedge clk); run_op("mult_m1_2",   F_MULT,  32'hFFFF_FFFF,  32'd2,          2,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    @(negedge clk); run_op("multu_max_2", F_MULTU, 32'hFFFF_FFFF,  32'd2,          2,  32'd1,          32'hFFFF_FFFE);
    @(negedge clk); run_op("divu_5_0",    F_DIVU,  32'd5,          32'd0,          1,  32'd5,          32'hFFFF_FFFF);
    @(negedge clk); run_op("div_m5_0",    F_DIV,   32'hFFFF_FFFB,  32'd0,          1,  32'hFFFF_FFFB,  32'hFFFF_FFFF);

    // Flush at divide iteration 10, then accept a new op the very next cycle
    @(negedge clk); in_valid = 1'b1; func = F_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk); in_valid = 1'b0; func = F_ADD;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div_stall", 64'(stall_req), 64'd0);
    check("flush_div_rv", 64'(result_valid), 64'd0);
    @(negedge clk); flush = 1'b0;
    run_op("divu_9_3_after_flush", F_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);

    // Flush in DONE suppresses the write pulse
    @(negedge clk); in_valid = 1'b1; func = F_DIVU; src_a = 32'd5; src_b = 32'd0;
    @(negedge clk); in_valid = 1'b0; func = F_ADD; flush = 1'b1;
    #1;
    check("flush_done_rv", 64'(result_valid), 64'd0);
    check("flush_done_stall", 64'(stall_req), 64'd0);
    @(negedge clk); flush = 1'b0;
    #1;
    check("flush_done_busy", 64'(busy), 64'd0);

    // Flush together with a start in IDLE: no start
    @(negedge clk); in_valid = 1'b1; func = F_MULT; src_a = 32'd3; src_b = 32'd4; flush = 1'b1;
    #1;
    check("flush_start_stall", 64'(stall_req), 64'd0);
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_busy", 64'(busy), 64'd0);

    // Async reset mid-divide
    @(negedge clk); in_valid = 1'b1; func = F_DIVU; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk); in_valid = 1'b0; func = F_ADD;
    repeat (4) @(negedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 64'(stall_req), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rv", 64'(result_valid), 64'd0);
    check("mid_rst_hi", 64'(hi_o), 64'd0);
    check("mid_rst_lo", 64'(lo_o), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); run_op("multu_3_5", F_MULTU, 32'd3, 32'd5, 2, 32'd0, 32'd15);

    // Back-to-back non-muldiv ops never stall
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; func = F_ADD + 6'(i); src_a = 32'd11; src_b = 32'd0;
      #1;
      check("alu_op_stall", 64'(stall_req), 64'd0);
      check("alu_op_busy", 64'(busy), 64'd0);
    end
    @(negedge clk); in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the EXE-stage HI/LO arithmetic: MULT, MULTU, DIV, DIVU.
- Takes the 6-bit ALU function code produced by ALU control, captures operands, and runs an iterative divider or a 2-stage multiplier.
- Holds the pipeline via stall_req until the result is ready, then delivers a one-cycle HI/LO write.
- Sits beside the ALU in EXE; stall_req feeds the pipeline stall controller.

Parameters:
- DIV_ITER, 32, number of radix-2 divide iterations; equals operand width.
- DATA_W, 32, operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  EXE holds a valid, non-annulled instruction.
- func  in  6  ALU function code; only FUNCT_MULT/MULTU/DIV/DIVU start an operation.
- src_a  in  32  rs operand (dividend / multiplicand).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  pipeline flush (exception/eret); cancels any operation.
- stall_req  out  1  hold IF..EXE this cycle.
- busy  out  1  an operation is in flight (state != IDLE).
- result_valid  out  1  one-cycle pulse; HI/LO written this cycle.
- hi_o  out  32  HI result (remainder / product[63:32]).
- lo_o  out  32  LO result (quotient / product[31:0]).

Behaviour:
- Reset (rst=0, async): state=IDLE; counter=0; all internal registers 0; stall_req=0, busy=0, result_valid=0, hi_o=0, lo_o=0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- start = in_valid & ~flush & func ∈ {MULT, MULTU, DIV, DIVU}, evaluated only in IDLE.
- IDLE: stall_req = start (combinational).
  - On start, latch operands, signedness and op type.
  - MULT/MULTU -> MUL_RUN.
  - DIV/DIVU with src_b=0 -> DONE.
  - Other DIV/DIVU -> DIV_RUN with counter=0.
- MUL_RUN (1 cycle): register the full 64-bit product (33x33 sign-extended for MULT, zero-extended for MULTU); -> DONE. stall_req=1.
- DIV_RUN: one restoring iteration per cycle on operand magnitudes (|a|, |b| for DIV; raw values for DIVU); counter increments. stall_req=1.
  - When counter reaches DIV_ITER-1, the iteration completes and the state moves to DONE.
- DONE (1 cycle): stall_req=0, result_valid=1, hi_o/lo_o driven from final registers; -> IDLE unconditionally. The pipeline advances this cycle, so the same instruction is never re-accepted.
- Signed fix-up, applied when entering DONE:
  - Quotient is negated iff sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
- Divide by zero: hi=dividend (src_a as captured), lo=32'hFFFFFFFF, for both DIV and DIVU.
- Latency from the accept cycle T0:
  - MULT: result_valid at T2.
  - DIV: result_valid at T1+DIV_ITER (T33).
  - Divide by zero: result_valid at T1.
- hi_o/lo_o hold their last values outside DONE; consumers qualify with result_valid.
- flush in any non-IDLE state: next state IDLE, no result_valid, stall_req=0 in the flush cycle. flush in DONE suppresses result_valid.
- flush together with start in IDLE: no start.
- Operands are captured at T0; later changes on src_a/src_b are ignored.
- Async reset mid-operation aborts immediately to reset values.
- busy = (state != IDLE).

Decomposition:
- defines.v (shared include): FUNCT_MULT 6'h18, FUNCT_MULTU 6'h19, FUNCT_DIV 6'h1A, FUNCT_DIVU 6'h1B (existing or added); state encodings MD_IDLE, MD_MUL, MD_DIV, MD_DONE; DivByZero result constant.
- One sub-module: div_iter_core, the combinational one-step restoring subtract/shift on {remainder, quotient}. The sequencer owns the FSM, counter, sign handling and registers.

Test Plan:
- DIVU 100/7 accepted at T0 -> stall_req high T0..T32; result_valid only at T33; lo=14, hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- MULT 0xFFFFFFFF*2 -> T2 result: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU 0xFFFFFFFF*2 -> T2 result: hi=1, lo=0xFFFFFFFE.
- DIVU 5/0 -> result_valid at T1: hi=5, lo=0xFFFFFFFF; stall_req high only at T0.
- DIV started, flush at iteration 10 -> next cycle IDLE, no result_valid, stall_req=0.
  - A new DIVU 9/3 is accepted the following cycle -> lo=3, hi=0.
  - Repeat with rst pulsed low mid-DIV: all outputs 0 immediately.
- func=ADD (0x20) with in_valid=1 and back-to-back non-muldiv ops -> stall_req stays 0, busy stays 0.
